// File: rtl/multicycle_adder_if.sv
// multicycle_adder_if
//   Handshake and operand/result bundle for multicycle_adder.
//   Parameter WIDTH: operand/result width.
//   master (controller): drives start, a, b, cin, sub; observes busy, done,
//                        sum, cout, overflow.
//   slave  (adder)     : the mirror image of master.
interface multicycle_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output start, a, b, cin, sub,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/multicycle_adder.sv
// multicycle_adder
//   Sequential ripple adder/subtractor: a WIDTH-bit operation is processed
//   CHUNK bits per clock, N = WIDTH/CHUNK cycles per operation, with a
//   registered carry between chunks. sub=1 computes a + ~b + 1 (cin ignored).
//   WIDTH must be a positive multiple of CHUNK.
//   Ports:
//     clk    : rising-edge clock
//     rst_n  : asynchronous active-low reset (aborts any operation)
//     bus    : slave side of multicycle_adder_if
//              start/a/b/cin/sub in; busy/done/sum/cout/overflow out
module multicycle_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    multicycle_adder_if.slave   bus
);

    localparam int unsigned N     = WIDTH / CHUNK;
    localparam int unsigned CNT_W = $clog2(N + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [WIDTH-1:0]   opa_q,   opa_d;
    logic [WIDTH-1:0]   opb_q,   opb_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   res_q,   res_d;
    logic [WIDTH-1:0]   sum_q,   sum_d;
    logic               cout_q,  cout_d;
    logic               ovf_q,   ovf_d;
    logic               done_q,  done_d;

    logic [CHUNK:0]     chunk_full;
    logic [CHUNK-1:0]   chunk_sum;
    logic               chunk_cout;
    logic               msb_cin;
    logic [WIDTH-1:0]   res_shift;
    logic               last_chunk;

    // One CHUNK-bit ripple slice; the only combinational adder path.
    assign chunk_full = {1'b0, opa_q[CHUNK-1:0]}
                      + {1'b0, opb_q[CHUNK-1:0]}
                      + {{CHUNK{1'b0}}, carry_q};
    assign chunk_sum  = chunk_full[CHUNK-1:0];
    assign chunk_cout = chunk_full[CHUNK];

    // Carry into the slice MSB recovered from the MSB sum bit: s = a ^ b ^ c.
    // Works for CHUNK=1, where it reduces to carry_q.
    assign msb_cin    = opa_q[CHUNK-1] ^ opb_q[CHUNK-1] ^ chunk_sum[CHUNK-1];

    assign last_chunk = (cnt_q == CNT_W'(N - 1));

    // New chunk enters at the top; after N shifts chunk 0 sits at bit 0.
    generate
        if (CHUNK == WIDTH) begin : g_single
            assign res_shift = chunk_sum;
        end else begin : g_multi
            assign res_shift = {chunk_sum, res_q[WIDTH-1:CHUNK]};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        carry_d = carry_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    opa_d   = bus.a;
                    opb_d   = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub ? 1'b1 : bus.cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                opa_d   = opa_q >> CHUNK;
                opb_d   = opb_q >> CHUNK;
                carry_d = chunk_cout;
                res_d   = res_shift;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_chunk) begin
                    sum_d   = res_shift;
                    cout_d  = chunk_cout;
                    ovf_d   = msb_cin ^ chunk_cout;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            carry_q <= carry_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy     = (state_q == RUN);
    assign bus.done     = done_q;
    assign bus.sum      = sum_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_multicycle_adder.sv
// tb_multicycle_adder
//   Directed and random checks of multicycle_adder in three configurations:
//   8/2 (main), 16/4 and 8/8. Expected results come from integer arithmetic.
module tb_multicycle_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_adder_if #(.WIDTH(8))  bus8();
    multicycle_adder_if #(.WIDTH(16)) bus16();
    multicycle_adder_if #(.WIDTH(8))  bus88();

    multicycle_adder #(.WIDTH(8),  .CHUNK(2)) u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    multicycle_adder #(.WIDTH(16), .CHUNK(4)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
    multicycle_adder #(.WIDTH(8),  .CHUNK(8)) u_dut88 (.clk(clk), .rst_n(rst_n), .bus(bus88));

    int checks   = 0;
    int failures = 0;
    logic [7:0] held8 = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns {overflow, cout, sum[15:0]} from plain integer arithmetic.
    function automatic logic [17:0] ref_op(input int w, input logic [15:0] a, input logic [15:0] b,
                                           input logic cin, input logic sub);
        longint ua, ub, span, half, full, sa, sb, exact;
        logic ovf, co;
        logic [15:0] s;
        ua    = longint'(a);
        ub    = longint'(b);
        span  = longint'(1) << w;
        half  = span / 2;
        full  = sub ? ua + (span - 1 - ub) + 1 : ua + ub + longint'(cin);
        s     = 16'(full % span);
        co    = ((full / span) % 2) == 1;
        sa    = (ua >= half) ? ua - span : ua;
        sb    = (ub >= half) ? ub - span : ub;
        exact = sub ? sa - sb : sa + sb + longint'(cin);
        ovf   = (exact > half - 1) || (exact < -half);
        return {ovf, co, s};
    endfunction

    // Call just after a negedge; start is sampled at the next posedge.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub);
        bus8.a = a; bus8.b = b; bus8.cin = cin; bus8.sub = sub; bus8.start = 1'b1;
    endtask

    // Follows one accepted operation to its done cycle, scrambling inputs
    // during RUN; with inject, a second start is presented at edge k+2.
    task automatic expect8(input logic [7:0] es, input logic ec, input logic eo, input bit inject);
        @(negedge clk);
        bus8.start = 1'b0;
        bus8.a = 8'($urandom); bus8.b = 8'($urandom);
        bus8.cin = 1'($urandom); bus8.sub = 1'($urandom);
        check("busy8_accept", bus8.busy, 1);
        check("done8_accept", bus8.done, 0);
        check("hold8_accept", bus8.sum, held8);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            bus8.start = inject && (i == 1);
            if (inject && i == 1) begin
                bus8.a = 8'h11; bus8.b = 8'h22;
            end
            check("busy8_run", bus8.busy, 1);
            check("done8_run", bus8.done, 0);
            check("hold8_run", bus8.sum, held8);
        end
        @(negedge clk);
        bus8.start = 1'b0;
        check("done8_end", bus8.done, 1);
        check("busy8_end", bus8.busy, 0);
        check("sum8",  bus8.sum, es);
        check("cout8", bus8.cout, ec);
        check("ovf8",  bus8.overflow, eo);
        held8 = es;
    endtask

    task automatic idle8();
        @(negedge clk);
        check("done8_fall", bus8.done, 0);
        check("busy8_idle", bus8.busy, 0);
        check("hold8_idle", bus8.sum, held8);
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub,
                        input logic [15:0] es, input logic ec, input logic eo);
        bus16.a = a; bus16.b = b; bus16.cin = cin; bus16.sub = sub; bus16.start = 1'b1;
        @(negedge clk);
        bus16.start = 1'b0;
        check("busy16_accept", bus16.busy, 1);
        repeat (3) @(negedge clk);
        check("done16_run", bus16.done, 0);
        @(negedge clk);
        check("done16_end", bus16.done, 1);
        check("sum16",  bus16.sum, es);
        check("cout16", bus16.cout, ec);
        check("ovf16",  bus16.overflow, eo);
    endtask

    task automatic op88(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub,
                        input logic [7:0] es, input logic ec, input logic eo);
        bus88.a = a; bus88.b = b; bus88.cin = cin; bus88.sub = sub; bus88.start = 1'b1;
        @(negedge clk);
        bus88.start = 1'b0;
        check("busy88_accept", bus88.busy, 1);
        check("done88_accept", bus88.done, 0);
        @(negedge clk);
        check("done88_end", bus88.done, 1);
        check("busy88_end", bus88.busy, 0);
        check("sum88",  bus88.sum, es);
        check("cout88", bus88.cout, ec);
        check("ovf88",  bus88.overflow, eo);
    endtask

    logic [17:0] r;
    logic [15:0] ra, rb;
    logic rc, rs;

    initial begin
        bus8.start = 0;  bus8.a = '0;  bus8.b = '0;  bus8.cin = 0;  bus8.sub = 0;
        bus16.start = 0; bus16.a = '0; bus16.b = '0; bus16.cin = 0; bus16.sub = 0;
        bus88.start = 0; bus88.a = '0; bus88.b = '0; bus88.cin = 0; bus88.sub = 0;

        #1;
        check("rst_busy8", bus8.busy, 0);
        check("rst_done8", bus8.done, 0);
        check("rst_sum8",  bus8.sum, 0);
        check("rst_cout8", bus8.cout, 0);
        check("rst_ovf8",  bus8.overflow, 0);
        check("rst_busy16", bus16.busy, 0);
        check("rst_sum16",  bus16.sum, 0);
        check("rst_busy88", bus88.busy, 0);
        check("rst_sum88",  bus88.sum, 0);

        @(negedge clk);
        rst_n = 1'b1;

        // Signed overflow, ignored start at k+2, back-to-back start in done cycle.
        issue8(8'h5A, 8'h3C, 1'b0, 1'b0);
        expect8(8'h96, 1'b0, 1'b1, 1'b1);
        issue8(8'h01, 8'h02, 1'b0, 1'b0);
        expect8(8'h03, 1'b0, 1'b0, 1'b0);
        idle8();

        issue8(8'hFF, 8'h01, 1'b1, 1'b0);
        expect8(8'h01, 1'b1, 1'b0, 1'b0);
        issue8(8'h10, 8'h20, 1'b0, 1'b1);
        expect8(8'hF0, 1'b0, 1'b0, 1'b0);
        issue8(8'h80, 8'h01, 1'b1, 1'b1);
        expect8(8'h7F, 1'b1, 1'b1, 1'b0);
        idle8();

        for (int n = 0; n < 16; n++) begin
            ra = 16'($urandom_range(0, 255));
            rb = 16'($urandom_range(0, 255));
            rc = 1'($urandom);
            rs = 1'($urandom);
            r  = ref_op(8, ra, rb, rc, rs);
            issue8(ra[7:0], rb[7:0], rc, rs);
            expect8(r[7:0], r[16], r[17], 1'b0);
        end
        idle8();

        // Reset between edges k+2 and k+3 of a running operation.
        issue8(8'h5A, 8'h3C, 1'b0, 1'b0);
        @(negedge clk);
        bus8.start = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", bus8.busy, 0);
        check("mid_rst_done", bus8.done, 0);
        check("mid_rst_sum",  bus8.sum, 0);
        check("mid_rst_cout", bus8.cout, 0);
        check("mid_rst_ovf",  bus8.overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        held8 = 8'h00;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            check("post_rst_done", bus8.done, 0);
            check("post_rst_busy", bus8.busy, 0);
        end

        op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        for (int n = 0; n < 6; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            r  = ref_op(16, ra, rb, rc, rs);
            op16(ra, rb, rc, rs, r[15:0], r[16], r[17]);
        end

        op88(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        for (int n = 0; n < 6; n++) begin
            ra = 16'($urandom_range(0, 255));
            rb = 16'($urandom_range(0, 255));
            rc = 1'($urandom);
            rs = 1'($urandom);
            r  = ref_op(8, ra, rb, rc, rs);
            op88(ra[7:0], rb[7:0], rc, rs, r[7:0], r[16], r[17]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
